// File: rtl/pipe_scroller.sv
// Single-pipe scroller feeding the collision checker: scrolls, respawns with an
// LFSR-derived gap height and scores passes. Optional macro: PIPE_SPEEDUP_EN.
module pipe_scroller #(
  parameter int SCREEN_W = 640,
  parameter int PIPE_W   = 80,
  parameter int SPEED    = 2,
  parameter int Y_MIN    = 40,
  parameter int Y_RANGE  = 300
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Freeze,
  input  logic       Frame_Tick,
  input  logic [9:0] Bird_X,
  output logic [9:0] X_Edge,
  output logic [9:0] Y_Edge,
  output logic       Pipe_Valid,
  output logic [7:0] Score,
  output logic       Score_Pulse,
  output logic       Q_Idle,
  output logic       Q_Run,
  output logic       Q_Freeze
);

  // One-hot encoding so the state flags are the state register bits themselves.
  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_RUN    = 3'b010,
    S_FREEZE = 3'b100
  } state_t;

  state_t      state, state_next;
  logic [15:0] lfsr;
  logic        passed, passed_next;
  logic [9:0]  x_next, y_next;
  logic [7:0]  score_next;
  logic        pulse_next;
  logic        respawn;
  logic [8:0]  gap_raw, gap;
  logic [9:0]  new_y;
  logic [9:0]  step;
  logic [10:0] right_edge;
  logic        feedback;

  assign {Q_Freeze, Q_Run, Q_Idle} = state;

  // Y_RANGE > 256 keeps a 9-bit draw within two ranges, so one subtract folds it.
  assign gap_raw = lfsr[8:0];
  assign gap     = (gap_raw >= 9'(Y_RANGE)) ? (gap_raw - 9'(Y_RANGE)) : gap_raw;
  assign new_y   = 10'(Y_MIN) + {1'b0, gap};

`ifdef PIPE_SPEEDUP_EN
  logic [4:0] bonus;
  assign bonus = (Score[7:3] > 5'd3) ? 5'd3 : Score[7:3];
  assign step  = 10'(SPEED) + {5'd0, bonus};
`else
  assign step  = 10'(SPEED);
`endif

  // 11-bit right edge so a pipe near the right border cannot wrap below Bird_X.
  assign right_edge = {1'b0, X_Edge} + 11'(PIPE_W);
  assign feedback   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Start and Ack are level inputs: Start is only acted on in idle, Ack only in
  // freeze; there is no ready/acknowledge back to the source.
  always_comb begin
    state_next  = state;
    x_next      = X_Edge;
    y_next      = Y_Edge;
    score_next  = Score;
    pulse_next  = 1'b0;
    passed_next = passed;
    respawn     = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          x_next      = 10'(SCREEN_W);
          y_next      = new_y;
          score_next  = 8'd0;
          passed_next = 1'b0;
          state_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (Freeze) begin
          state_next = S_FREEZE;
        end else begin
          if (Frame_Tick) begin
            if (X_Edge < step) begin
              x_next      = 10'(SCREEN_W);
              y_next      = new_y;
              passed_next = 1'b0;
              respawn     = 1'b1;
            end else begin
              x_next = X_Edge - step;
            end
          end
          if (!respawn && !passed && (right_edge < {1'b0, Bird_X})) begin
            passed_next = 1'b1;
            if (Score != 8'hFF) begin
              score_next = Score + 8'd1;
              pulse_next = 1'b1;
            end
          end
        end
      end
      S_FREEZE: begin
        if (Ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      X_Edge      <= 10'(SCREEN_W);
      Y_Edge      <= 10'(Y_MIN);
      Score       <= 8'd0;
      Score_Pulse <= 1'b0;
      passed      <= 1'b0;
      lfsr        <= 16'hACE1;
      Pipe_Valid  <= 1'b0;
    end else begin
      state       <= state_next;
      X_Edge      <= x_next;
      Y_Edge      <= y_next;
      Score       <= score_next;
      Score_Pulse <= pulse_next;
      passed      <= passed_next;
      lfsr        <= {lfsr[14:0], feedback};
      Pipe_Valid  <= (state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: vector table, directed corner cases and
// randomized traffic against a behavioural model; a fast instance covers saturation.
module tb_pipe_scroller;
  localparam int SCREEN_W = 640;
  localparam int PIPE_W   = 80;
  localparam int SPEED    = 2;
  localparam int Y_MIN    = 40;
  localparam int Y_RANGE  = 300;

  logic       Clk, reset, Start, Ack, Freeze, Frame_Tick;
  logic [9:0] Bird_X, X_Edge, Y_Edge;
  logic       Pipe_Valid, Score_Pulse, Q_Idle, Q_Run, Q_Freeze;
  logic [7:0] Score;

  logic       rst_b, start_b, tick_b;
  logic [9:0] x_b, y_b;
  logic       valid_b, pulse_b, idle_b, run_b, frz_b;
  logic [7:0] score_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_count = 0;

  // behavioural model state: mode 0 idle, 1 run, 2 freeze
  int          m_mode, m_x, m_y, m_score, m_passed, m_pulse;
  logic [15:0] m_lfsr;

  typedef struct {
    logic st, ak, fz, tk;
    int   bx;
    int   mode;
    int   x;
    int   score;
  } vec_t;
  vec_t vecs[13];

  pipe_scroller dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Freeze(Freeze),
    .Frame_Tick(Frame_Tick), .Bird_X(Bird_X), .X_Edge(X_Edge), .Y_Edge(Y_Edge),
    .Pipe_Valid(Pipe_Valid), .Score(Score), .Score_Pulse(Score_Pulse),
    .Q_Idle(Q_Idle), .Q_Run(Q_Run), .Q_Freeze(Q_Freeze)
  );

  pipe_scroller #(.SPEED(7)) dut_fast (
    .Clk(Clk), .reset(rst_b), .Start(start_b), .Ack(1'b0), .Freeze(1'b0),
    .Frame_Tick(tick_b), .Bird_X(10'd1023), .X_Edge(x_b), .Y_Edge(y_b),
    .Pipe_Valid(valid_b), .Score(score_b), .Score_Pulse(pulse_b),
    .Q_Idle(idle_b), .Q_Run(run_b), .Q_Freeze(frz_b)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input logic [15:0] l);
    return Y_MIN + ((int'(l) % 512) % Y_RANGE);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = SCREEN_W; m_y = Y_MIN; m_score = 0;
    m_passed = 0; m_pulse = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic st, ak, fz, tk, input int bx);
    int step, old_x, old_score;
    bit respawn;
    old_x = m_x; old_score = m_score; respawn = 0; m_pulse = 0;
    step = SPEED;
`ifdef PIPE_SPEEDUP_EN
    step = SPEED + (((m_score / 8) > 3) ? 3 : (m_score / 8));
`endif
    case (m_mode)
      0: begin
        if (st) begin
          m_x = SCREEN_W; m_y = gap_of(m_lfsr); m_score = 0; m_passed = 0; m_mode = 1;
        end
      end
      1: begin
        if (fz) m_mode = 2;
        else begin
          if (tk) begin
            if (old_x < step) begin
              m_x = SCREEN_W; m_y = gap_of(m_lfsr); m_passed = 0; respawn = 1;
            end else m_x = old_x - step;
          end
          if (!respawn && m_passed == 0 && (old_x + PIPE_W) < bx) begin
            m_passed = 1;
            if (old_score < 255) begin
              m_score = old_score + 1; m_pulse = 1;
            end
          end
        end
      end
      default: if (ak) m_mode = 0;
    endcase
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q_idle"}, Q_Idle, m_mode == 0);
    chk({tag, ".q_run"}, Q_Run, m_mode == 1);
    chk({tag, ".q_freeze"}, Q_Freeze, m_mode == 2);
    chk({tag, ".pipe_valid"}, Pipe_Valid, m_mode != 0);
    chk({tag, ".x_edge"}, X_Edge, m_x);
    chk({tag, ".y_edge"}, Y_Edge, m_y);
    chk({tag, ".score"}, Score, m_score);
    chk({tag, ".score_pulse"}, Score_Pulse, m_pulse);
    if (Score_Pulse) pulse_count++;
  endtask

  // driver: called at a negedge, applies one clock of inputs and checks at the next negedge
  task automatic cycle(input logic st, ak, fz, tk, input int bx);
    Start = st; Ack = ak; Freeze = fz; Frame_Tick = tk; Bird_X = 10'(bx);
    @(posedge Clk);
    model_step(st, ak, fz, tk, bx);
    @(negedge Clk);
    check_all("cyc");
  endtask

  task automatic set_vec(input int i, input logic st, ak, fz, tk, input int mode, input int x);
    vecs[i].st = st; vecs[i].ak = ak; vecs[i].fz = fz; vecs[i].tk = tk;
    vecs[i].bx = 0; vecs[i].mode = mode; vecs[i].x = x; vecs[i].score = 0;
  endtask

  initial begin
    int pulses_b, bad_b, prev_b, guard;
    reset = 1'b1; Start = 1'b0; Ack = 1'b0; Freeze = 1'b0; Frame_Tick = 1'b0;
    Bird_X = 10'd0; rst_b = 1'b1; start_b = 1'b0; tick_b = 1'b0;
    model_reset();

    set_vec(0,  0, 0, 0, 0, 0, 640);
    set_vec(1,  0, 0, 0, 1, 0, 640);
    set_vec(2,  1, 0, 0, 0, 1, 640);
    set_vec(3,  0, 0, 0, 1, 1, 638);
    set_vec(4,  0, 0, 0, 0, 1, 638);
    set_vec(5,  0, 0, 0, 1, 1, 636);
    set_vec(6,  1, 0, 0, 1, 1, 634);
    set_vec(7,  0, 0, 1, 1, 2, 634);
    set_vec(8,  0, 0, 0, 1, 2, 634);
    set_vec(9,  1, 0, 0, 0, 2, 634);
    set_vec(10, 0, 1, 0, 0, 0, 634);
    set_vec(11, 0, 0, 0, 1, 0, 634);
    set_vec(12, 1, 0, 0, 0, 1, 640);

    repeat (2) @(negedge Clk);
    check_all("por");
    reset = 1'b0;

    // idle ignores ticks
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, (i % 2) == 0, 0);
    chk("idle.x", X_Edge, 640);
    chk("idle.y", Y_Edge, 40);
    chk("idle.score", Score, 0);
    chk("idle.q_idle", Q_Idle, 1);
    chk("idle.valid", Pipe_Valid, 0);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].st, vecs[i].ak, vecs[i].fz, vecs[i].tk, vecs[i].bx);
      chk($sformatf("vec%0d.q_idle", i), Q_Idle, vecs[i].mode == 0);
      chk($sformatf("vec%0d.q_run", i), Q_Run, vecs[i].mode == 1);
      chk($sformatf("vec%0d.q_freeze", i), Q_Freeze, vecs[i].mode == 2);
      chk($sformatf("vec%0d.valid", i), Pipe_Valid, vecs[i].mode != 0);
      chk($sformatf("vec%0d.x", i), X_Edge, vecs[i].x);
      chk($sformatf("vec%0d.score", i), Score, vecs[i].score);
    end

    // first pass and respawn, ticks four cycles apart
    pulse_count = 0;
    for (int k = 1; k <= 321; k++) begin
      cycle(0, 0, 0, 1, 100);
      repeat (3) cycle(0, 0, 0, 0, 100);
      if (k == 311) begin
        chk("pass1.x", X_Edge, 18); chk("pass1.score", Score, 1); chk("pass1.pulses", pulse_count, 1);
      end
      if (k == 320) begin
        chk("edge0.x", X_Edge, 0); chk("edge0.pulses", pulse_count, 1);
      end
      if (k == 321) begin
        chk("respawn.x", X_Edge, 640); chk("respawn.score", Score, 1);
        chk("respawn.y_range", (Y_Edge >= 40) && (Y_Edge <= 339), 1);
      end
    end
    for (int k = 1; k <= 311; k++) begin
      cycle(0, 0, 0, 1, 100);
      repeat (3) cycle(0, 0, 0, 0, 100);
    end
    chk("pass2.score", Score, 2);
    chk("pass2.pulses", pulse_count, 2);

    // freeze wins over a same-cycle tick at x=300
    guard = 0;
    while (m_x != 300 && guard < 1000) begin cycle(0, 0, 0, 1, 100); guard++; end
    chk("pre_freeze.x", X_Edge, 300);
    cycle(0, 0, 1, 1, 100);
    chk("freeze.x", X_Edge, 300); chk("freeze.q_freeze", Q_Freeze, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 100);
      chk("frozen.x", X_Edge, 300);
    end
    cycle(0, 1, 0, 0, 100);
    chk("ack.q_idle", Q_Idle, 1); chk("ack.score", Score, 2);
    cycle(1, 0, 0, 0, 100);
    chk("restart.score", Score, 0); chk("restart.x", X_Edge, 640); chk("restart.q_run", Q_Run, 1);

    // asynchronous reset mid-run at x=200, score=5
    guard = 0;
    while (!(m_x == 200 && m_score == 5) && guard < 4000) begin cycle(0, 0, 0, 1, 1023); guard++; end
    chk("mid.x", X_Edge, 200); chk("mid.score", Score, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst.x", X_Edge, 640); chk("arst.y", Y_Edge, 40); chk("arst.score", Score, 0);
    chk("arst.pulse", Score_Pulse, 0); chk("arst.q_idle", Q_Idle, 1); chk("arst.q_run", Q_Run, 0);
    chk("arst.q_freeze", Q_Freeze, 0); chk("arst.valid", Pipe_Valid, 0);
    model_reset();
    @(negedge Clk);
    reset = 1'b0;
    check_all("post_rst");

    // many gap draws, every one inside the legal band
    for (int i = 0; i < 1000; i++) begin
      cycle(1, 0, 0, 0, 0);
      chk("gap.y_range", (Y_Edge >= 40) && (Y_Edge <= 339), 1);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1023));

    // saturation on the fast instance: every respawn scores immediately
    chk("fast.reset_score", score_b, 0);
    rst_b = 1'b0; start_b = 1'b1;
    @(negedge Clk);
    start_b = 1'b0; tick_b = 1'b1;
    pulses_b = 0; bad_b = 0; prev_b = score_b;
    for (int i = 0; i < 25000; i++) begin
      @(negedge Clk);
      if (pulse_b) begin
        pulses_b++;
        if (prev_b == 255) bad_b++;
      end
      prev_b = score_b;
    end
    chk("sat.score", score_b, 255);
    chk("sat.pulses", pulses_b, 255);
    chk("sat.late_pulses", bad_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
